// File: rtl/i_fetch_ctrl_pkg.sv
// rtl/i_fetch_ctrl_pkg.sv - shared types, constants and address slicing for the fetch sequencer
package i_fetch_ctrl_pkg;

  localparam int FC_ADDR_W    = 32;
  localparam int FC_BLK_SHIFT = 9;
  localparam int FC_NUM_SETS  = 16;
  localparam int FC_SET_W     = $clog2(FC_NUM_SETS);
  localparam int FC_TAG_W     = FC_ADDR_W - FC_BLK_SHIFT - FC_SET_W;
  localparam int HDR_BANK     = 4;

  localparam logic [1:0] MORPH_S = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HDR,
    ST_ROWS,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_DONE
  } fetch_state_e;

  function automatic logic [FC_SET_W-1:0] set_of(input logic [FC_ADDR_W-1:0] a);
    return a[FC_BLK_SHIFT +: FC_SET_W];
  endfunction

  function automatic logic [FC_TAG_W-1:0] tag_of(input logic [FC_ADDR_W-1:0] a);
    return a[FC_ADDR_W-1 : FC_BLK_SHIFT+FC_SET_W];
  endfunction

endpackage

// File: rtl/i_tag_array.sv
// rtl/i_tag_array.sv - direct-mapped valid+tag store with a registered hit compare
module i_tag_array
  import i_fetch_ctrl_pkg::*;
#(
  parameter int NUM_SETS = FC_NUM_SETS,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = FC_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] lk_set_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             hit_o,
  input  logic             ins_en_i,
  input  logic [SET_W-1:0] ins_set_i,
  input  logic [TAG_W-1:0] ins_tag_i,
  input  logic             flush_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tags_q [NUM_SETS];
  logic                hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (ins_en_i) begin
      valid_q[ins_set_i] <= 1'b1;
    end
  end

  // Tag payload needs no reset; the valid bit gates every compare.
  always_ff @(posedge clk) begin
    if (ins_en_i) begin
      tags_q[ins_set_i] <= ins_tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= valid_q[lk_set_i] && (tags_q[lk_set_i] == lk_tag_i);
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/i_fetch_ctrl.sv
// rtl/i_fetch_ctrl.sv - instruction-cache fetch sequencer: arbitration, lookup, bank streaming, L2 refill
module i_fetch_ctrl
  import i_fetch_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 5,
  parameter int CHUNKS    = 8,
  parameter int NUM_SETS  = FC_NUM_SETS,
  parameter int BLK_SHIFT = FC_BLK_SHIFT,
  parameter int ADDR_W    = FC_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  morph_mode_i,
  input  logic                        flush_i,
  input  logic                        fetch_req_i,
  input  logic [ADDR_W-1:0]           fetch_addr_i,
  output logic                        fetch_ack_o,
  output logic                        fetch_done_o,
  input  logic                        pf_req_i,
  input  logic [ADDR_W-1:0]           pf_addr_i,
  output logic                        pf_ack_o,
  output logic [NUM_BANKS-1:0]        bank_rd_en_o,
  output logic [$clog2(NUM_SETS)-1:0] bank_set_o,
  output logic [$clog2(CHUNKS)-1:0]   bank_chunk_o,
  output logic                        hdr_valid_o,
  output logic                        row_valid_o,
  output logic                        l2_req_o,
  output logic [ADDR_W-1:0]           l2_addr_o,
  input  logic                        l2_gnt_i,
  input  logic                        l2_rsp_valid_i,
  input  logic                        l2_rsp_last_i,
  output logic                        refill_we_o,
  output logic [2:0]                  refill_bank_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int CHK_W = $clog2(CHUNKS);
  localparam int BEATS = NUM_BANKS * CHUNKS;
  localparam int CNT_W = $clog2(BEATS);
  localparam int TAG_W = ADDR_W - BLK_SHIFT - SET_W;

  localparam logic [NUM_BANKS-1:0] HDR_MASK = NUM_BANKS'(1) << HDR_BANK;
  localparam logic [NUM_BANKS-1:0] ROW_MASK = ~HDR_MASK;
  localparam logic [ADDR_W-1:0]    BLK_MASK = (ADDR_W'(1) << BLK_SHIFT) - ADDR_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, lk_addr;
  logic              is_pf_q, is_pf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              err_q, err_d;
  logic              hit, ins_en, tag_flush, last_beat;

  i_tag_array #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W),
    .TAG_W    (TAG_W)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_set_i  (set_of(lk_addr)),
    .lk_tag_i  (tag_of(lk_addr)),
    .hit_o     (hit),
    .ins_en_i  (ins_en),
    .ins_set_i (set_of(addr_q)),
    .ins_tag_i (tag_of(addr_q)),
    .flush_i   (tag_flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      is_pf_q      <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      is_pf_q      <= is_pf_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
    end
  end

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign busy_o    = (state_q != ST_IDLE);
  assign err_o     = err_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    is_pf_d       = is_pf_q;
    cnt_d         = cnt_q;
    flush_pend_d  = flush_pend_q;
    err_d         = err_q;
    lk_addr       = addr_q;
    ins_en        = 1'b0;
    tag_flush     = 1'b0;
    fetch_ack_o   = 1'b0;
    fetch_done_o  = 1'b0;
    pf_ack_o      = 1'b0;
    bank_rd_en_o  = '0;
    bank_set_o    = '0;
    bank_chunk_o  = '0;
    hdr_valid_o   = 1'b0;
    row_valid_o   = 1'b0;
    l2_req_o      = 1'b0;
    l2_addr_o     = '0;
    refill_we_o   = 1'b0;
    refill_bank_o = '0;

    // A flush seen mid-transaction is held until the sequencer is idle again.
    if (state_q != ST_IDLE && flush_i) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        lk_addr = fetch_req_i ? fetch_addr_i : pf_addr_i;
        if (flush_i || flush_pend_q) begin
          tag_flush    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (rst_n && fetch_req_i) begin
          fetch_ack_o = 1'b1;
          addr_d      = fetch_addr_i;
          is_pf_d     = 1'b0;
          state_d     = ST_LOOKUP;
        end else if (rst_n && pf_req_i && morph_mode_i == MORPH_S) begin
          pf_ack_o = 1'b1;
          addr_d   = pf_addr_i;
          is_pf_d  = 1'b1;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cnt_d = '0;
        if (!hit) begin
          state_d = ST_MISS_REQ;
        end else if (is_pf_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        bank_rd_en_o = HDR_MASK;
        bank_set_o   = set_of(addr_q);
        hdr_valid_o  = 1'b1;
        cnt_d        = '0;
        state_d      = ST_ROWS;
      end
      ST_ROWS: begin
        bank_rd_en_o = ROW_MASK;
        bank_set_o   = set_of(addr_q);
        bank_chunk_o = cnt_q[CHK_W-1:0];
        row_valid_o  = 1'b1;
        if (cnt_q == CNT_W'(CHUNKS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        fetch_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_MISS_REQ: begin
        l2_req_o  = 1'b1;
        l2_addr_o = addr_q & ~BLK_MASK;
        if (l2_gnt_i) begin
          cnt_d   = '0;
          state_d = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (l2_rsp_valid_i) begin
          refill_we_o   = 1'b1;
          refill_bank_o = 3'(cnt_q / CNT_W'(CHUNKS));
          bank_chunk_o  = CHK_W'(cnt_q % CNT_W'(CHUNKS));
          bank_set_o    = set_of(addr_q);
          // Install on the marked last beat or on the final counted beat, whichever comes first.
          if (l2_rsp_last_i || last_beat) begin
            ins_en = 1'b1;
            cnt_d  = '0;
            if (l2_rsp_last_i != last_beat) begin
              err_d = 1'b1;
            end
            state_d = is_pf_q ? ST_IDLE : ST_HDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// tb/tb_i_fetch_ctrl.sv - self-checking bench for i_fetch_ctrl
module tb_i_fetch_ctrl;
  import i_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  morph_mode = 2'd0;
  logic        flush = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ack, fetch_done;
  logic        pf_req = 1'b0;
  logic [31:0] pf_addr = '0;
  logic        pf_ack;
  logic [4:0]  bank_rd_en;
  logic [3:0]  bank_set;
  logic [2:0]  bank_chunk;
  logic        hdr_valid, row_valid, l2_req;
  logic [31:0] l2_addr;
  logic        l2_gnt = 1'b0, l2_rsp_valid = 1'b0, l2_rsp_last = 1'b0;
  logic        refill_we;
  logic [2:0]  refill_bank;
  logic        busy, err;

  i_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .morph_mode_i(morph_mode), .flush_i(flush),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ack_o(fetch_ack),
    .fetch_done_o(fetch_done), .pf_req_i(pf_req), .pf_addr_i(pf_addr), .pf_ack_o(pf_ack),
    .bank_rd_en_o(bank_rd_en), .bank_set_o(bank_set), .bank_chunk_o(bank_chunk),
    .hdr_valid_o(hdr_valid), .row_valid_o(row_valid), .l2_req_o(l2_req), .l2_addr_o(l2_addr),
    .l2_gnt_i(l2_gnt), .l2_rsp_valid_i(l2_rsp_valid), .l2_rsp_last_i(l2_rsp_last),
    .refill_we_o(refill_we), .refill_bank_o(refill_bank), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;
  logic [5:0] exp_q[$];
  logic [3:0] exp_set_g = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [63:0] outs();
    return 64'({fetch_ack, fetch_done, pf_ack, bank_rd_en, bank_set, bank_chunk, hdr_valid,
                row_valid, l2_req, l2_addr, refill_we, refill_bank, busy, err});
  endfunction

  // Scoreboard side: refill beats and bank reads as they leave the DUT.
  int row_k = 0;
  always begin
    @(negedge clk);
    #2;
    if (refill_we) begin
      chk("refill_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("refill_bank", 64'(refill_bank), 64'(e[5:3]));
        chk("refill_chunk", 64'(bank_chunk), 64'(e[2:0]));
        chk("refill_set", 64'(bank_set), 64'(exp_set_g));
      end
    end
    if (hdr_valid) begin
      chk("hdr_rd_en", 64'(bank_rd_en), 64'h10);
      chk("hdr_chunk_set", 64'({bank_chunk, bank_set}), 64'({3'd0, exp_set_g}));
      row_k = 0;
    end
    if (row_valid) begin
      chk("row_rd_en", 64'(bank_rd_en), 64'h0f);
      chk("row_chunk", 64'(bank_chunk), 64'(row_k));
      chk("row_set", 64'(bank_set), 64'(exp_set_g));
      row_k++;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        pf;
    logic [1:0]  morph;
    logic        pre_flush;
    logic        flush_rows;
    int          nbeats;
    int          rst_beat;
    logic        exp_ack;
    logic        exp_miss;
    logic [31:0] exp_l2;
    logic [3:0]  exp_set;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  task automatic run_vec(input int idx, input vec_t v);
    int ack_c, done_c, hdr_n, row_n, done_n, ph, gw, nb;
    logic got, other, miss, l2_ok, fin, aborted, flushed;
    logic [31:0] l2a;
    ack_c = 0; done_c = -1; hdr_n = 0; row_n = 0; done_n = 0; ph = 0; gw = 0; nb = 0;
    got = 0; other = 0; miss = 0; l2_ok = 1; fin = 0; aborted = 0; flushed = 0; l2a = '0;
    exp_set_g = v.exp_set;
    if (v.pre_flush) begin
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
    end
    @(negedge clk);
    morph_mode = v.morph;
    if (v.pf) begin pf_req = 1'b1; pf_addr = v.addr; end
    else begin fetch_req = 1'b1; fetch_addr = v.addr; end
    for (int t = 0; t < 20; t++) begin
      if (t > 0) @(negedge clk);
      #2;
      if (v.pf ? fetch_ack : pf_ack) other = 1;
      if (v.pf ? pf_ack : fetch_ack) begin got = 1; ack_c = cyc; break; end
    end
    chk($sformatf("v%0d_ack", idx), 64'(got), 64'(v.exp_ack));
    chk($sformatf("v%0d_other_ack", idx), 64'(other), 64'd0);
    if (!got) begin
      chk($sformatf("v%0d_idle_no_ack", idx), 64'(busy), 64'd0);
      @(negedge clk); fetch_req = 0; pf_req = 0; morph_mode = 2'd0;
      return;
    end
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      fetch_req = 0; pf_req = 0; flush = 0;
      l2_gnt = 0; l2_rsp_valid = 0; l2_rsp_last = 0;
      if (ph == 1) l2_gnt = (gw >= 2);
      if (ph == 2 && nb < v.nbeats) begin
        if (v.rst_beat != 0 && nb == v.rst_beat) begin
          rst_n = 1'b0; aborted = 1;
        end else begin
          l2_rsp_valid = 1'b1;
          l2_rsp_last = (nb == v.nbeats - 1);
          exp_q.push_back({3'(nb / 8), 3'(nb % 8)});
          nb++;
        end
      end
      if (v.flush_rows && row_n == 1 && !flushed) begin flush = 1'b1; flushed = 1; end
      #2;
      if (aborted) begin
        chk($sformatf("v%0d_reset_outs_zero", idx), outs(), 64'd0);
        break;
      end
      if (l2_req) begin
        if (!miss) l2a = l2_addr;
        else if (l2_addr !== l2a) l2_ok = 0;
        miss = 1;
        if (l2_gnt) ph = 2;
        else begin ph = 1; gw++; end
      end
      if (hdr_valid) hdr_n++;
      if (row_valid) row_n++;
      if (fetch_done) begin done_n++; done_c = cyc; end
      if (!busy) begin fin = 1; break; end
    end
    chk($sformatf("v%0d_miss", idx), 64'(miss), 64'(v.exp_miss));
    if (v.exp_miss) chk($sformatf("v%0d_l2_addr", idx), 64'(l2a), 64'(v.exp_l2));
    chk($sformatf("v%0d_l2_addr_stable", idx), 64'(l2_ok), 64'd1);
    if (aborted) begin
      @(negedge clk); rst_n = 1'b1;
      chk($sformatf("v%0d_beats_left", idx), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      return;
    end
    chk($sformatf("v%0d_complete", idx), 64'(fin), 64'd1);
    chk($sformatf("v%0d_hdr_cnt", idx), 64'(hdr_n), v.pf ? 64'd0 : 64'd1);
    chk($sformatf("v%0d_row_cnt", idx), 64'(row_n), v.pf ? 64'd0 : 64'd8);
    chk($sformatf("v%0d_done_cnt", idx), 64'(done_n), v.pf ? 64'd0 : 64'd1);
    if (!v.pf && !v.exp_miss) chk($sformatf("v%0d_hit_latency", idx), 64'(done_c - ack_c), 64'd11);
    chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
    chk($sformatf("v%0d_beats_left", idx), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, pa, dc;
    logic both;
    //          addr          pf morph    pflsh frow nb  rst ack miss l2           set    err
    vecs[0]  = '{32'h0000_1200, 0, 2'd0,    0, 0, 40, 0,  1, 1, 32'h0000_1200, 4'd9,  0};
    vecs[1]  = '{32'h0000_1200, 0, 2'd0,    0, 0, 40, 0,  1, 0, 32'h0,         4'd9,  0};
    vecs[2]  = '{32'h0000_13FF, 0, 2'd0,    0, 0, 40, 0,  1, 0, 32'h0,         4'd9,  0};
    vecs[3]  = '{32'h0000_3200, 0, 2'd0,    0, 0, 40, 0,  1, 1, 32'h0000_3200, 4'd9,  0};
    vecs[4]  = '{32'h0000_1200, 0, 2'd0,    0, 0, 40, 0,  1, 1, 32'h0000_1200, 4'd9,  0};
    vecs[5]  = '{32'hFFFF_FFFF, 1, MORPH_S, 0, 0, 40, 0,  1, 1, 32'hFFFF_FE00, 4'd15, 0};
    vecs[6]  = '{32'hFFFF_FE00, 0, 2'd0,    0, 0, 40, 0,  1, 0, 32'h0,         4'd15, 0};
    vecs[7]  = '{32'h0000_1200, 1, MORPH_S, 0, 0, 40, 0,  1, 0, 32'h0,         4'd9,  0};
    vecs[8]  = '{32'h0000_1200, 1, 2'd2,    0, 0, 40, 0,  0, 0, 32'h0,         4'd9,  0};
    vecs[9]  = '{32'h0000_5400, 0, 2'd0,    0, 0, 21, 0,  1, 1, 32'h0000_5400, 4'd10, 1};
    vecs[10] = '{32'h0000_5400, 0, 2'd0,    0, 0, 40, 0,  1, 0, 32'h0,         4'd10, 1};
    vecs[11] = '{32'h0000_1200, 0, 2'd0,    0, 1, 40, 0,  1, 0, 32'h0,         4'd9,  1};
    vecs[12] = '{32'h0000_1200, 0, 2'd0,    0, 0, 40, 0,  1, 1, 32'h0000_1200, 4'd9,  1};
    vecs[13] = '{32'hFFFF_FE00, 0, 2'd0,    0, 0, 40, 0,  1, 1, 32'hFFFF_FE00, 4'd15, 1};
    vecs[14] = '{32'h0000_1200, 0, 2'd0,    1, 0, 40, 0,  1, 1, 32'h0000_1200, 4'd9,  1};
    vecs[15] = '{32'h0000_7600, 0, 2'd0,    0, 0, 40, 10, 1, 1, 32'h0000_7600, 4'd11, 0};
    vecs[16] = '{32'h0000_7600, 0, 2'd0,    0, 0, 40, 0,  1, 1, 32'h0000_7600, 4'd11, 0};

    @(negedge clk); #2;
    chk("reset_outs_zero", outs(), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #2;
    chk("post_reset_outs_zero", outs(), 64'd0);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Demand and prefetch raised together: demand first, prefetch right after fetch_done.
    fa = -1; pa = -1; dc = -1; both = 0;
    exp_set_g = 4'd11;
    @(negedge clk);
    morph_mode = MORPH_S;
    fetch_addr = 32'h0000_7600; pf_addr = 32'h0000_7600;
    fetch_req = 1'b1; pf_req = 1'b1;
    for (int t = 0; t < 60; t++) begin
      #2;
      if (fetch_ack && pf_ack) both = 1;
      if (fetch_ack && fa < 0) fa = cyc;
      if (fetch_done) dc = cyc;
      if (pf_ack) begin pa = cyc; break; end
      @(negedge clk);
      if (fa >= 0) fetch_req = 1'b0;
    end
    @(negedge clk); pf_req = 1'b0; fetch_req = 1'b0;
    chk("simul_both_ack", 64'(both), 64'd0);
    chk("simul_done_latency", 64'(dc - fa), 64'd11);
    chk("simul_pf_after_done", 64'(pa - dc), 64'd1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #2;
      if (!busy) break;
    end
    chk("final_idle", 64'(busy), 64'd0);
    chk("final_err_clear", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i_fetch_ctrl.md
Name: i_fetch_ctrl

Overview:
Fetch sequencer for the instruction-cache tile.
- Accepts demand block fetches from the G-tile and optional S-morph prefetches. Demand requests win arbitration.
- Performs a block-granular tag lookup.
- On a hit, reads the header bank, then streams the four row banks chunk by chunk to the decoder.
- On a miss, requests the block from L2, steers refill beats into the banks, then installs the tag.
- Sits between the G-tile fetch interface, the banked cache RAM/decoder, and the L2 port.

Parameters:
NUM_BANKS, 5, row banks 0..3 plus header bank 4
CHUNKS, 8, read/refill beats per bank per block
NUM_SETS, 16, direct-mapped tag sets (power of two)
BLK_SHIFT, 9, log2 of block alignment in bytes
ADDR_W, 32, block address width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
morph_mode  in  2  from morph_config_t; prefetch is enabled only when this equals MORPH_S
flush  in  1  pulse; invalidate all tags
fetch_req  in  1  demand request, level, held until fetch_ack
fetch_addr  in  ADDR_W  demand block address, stable while fetch_req is high
fetch_ack  out  1  one-cycle accept pulse
fetch_done  out  1  one-cycle pulse: block fully delivered
pf_req  in  1  prefetch request, level
pf_addr  in  ADDR_W  prefetch address
pf_ack  out  1  one-cycle accept pulse
bank_rd_en  out  NUM_BANKS  per-bank read strobe
bank_set  out  log2(NUM_SETS)  set index for reads and refill
bank_chunk  out  log2(CHUNKS)  chunk index
hdr_valid  out  1  header read issued this cycle
row_valid  out  1  row chunk read issued this cycle
l2_req  out  1  miss request
l2_addr  out  ADDR_W  block-aligned miss address
l2_gnt  in  1  L2 accepts l2_req
l2_rsp_valid  in  1  refill beat valid
l2_rsp_last  in  1  marks the final refill beat
refill_we  out  1  write the current beat into the bank
refill_bank  out  3  destination bank
busy  out  1  state is not IDLE
err  out  1  sticky refill beat-count mismatch

Behaviour:
- Reset values: all outputs 0, all tag valid bits 0, state IDLE.
- Reset asserted mid-operation aborts immediately; no tag is installed for the in-flight block.
- Address fields:
  - set = addr[BLK_SHIFT +: log2(NUM_SETS)]
  - tag = addr[ADDR_W-1 : BLK_SHIFT+log2(NUM_SETS)]
  - l2_addr = addr with bits [BLK_SHIFT-1:0] cleared.
- States: IDLE, LOOKUP, HDR, ROWS, MISS_REQ, MISS_WAIT, DONE.
- IDLE:
  - If fetch_req: pulse fetch_ack, latch the address and kind=demand, go to LOOKUP.
  - Else if pf_req and morph_mode==MORPH_S: pulse pf_ack, latch kind=prefetch, go to LOOKUP.
  - Never ack both requesters in the same cycle.
- LOOKUP (1 cycle):
  - demand hit -> HDR
  - prefetch hit -> IDLE, with no bank reads
  - any miss -> MISS_REQ
- HDR (1 cycle): bank_rd_en = 5'b10000, bank_chunk = 0, hdr_valid = 1.
- ROWS: CHUNKS cycles, chunk k = 0..CHUNKS-1. bank_rd_en = 5'b01111, row_valid = 1. After the last chunk, go to DONE.
- DONE (1 cycle): fetch_done = 1, then IDLE.
- Hit latency: ack in cycle A; LOOKUP A+1; HDR A+2; ROWS A+3..A+2+CHUNKS; fetch_done at A+3+CHUNKS.
- MISS_REQ: hold l2_req with l2_addr stable until the cycle l2_gnt is high, then go to MISS_WAIT.
- MISS_WAIT, beat counter b = 0..NUM_BANKS*CHUNKS-1:
  - Each l2_rsp_valid beat: refill_we = 1, refill_bank = b / CHUNKS, bank_chunk = b % CHUNKS.
  - Beats are accepted every cycle with no backpressure.
  - On l2_rsp_last, install tag and set valid.
  - err is set if l2_rsp_last arrives with b != NUM_BANKS*CHUNKS-1, or if b reaches the final value without l2_rsp_last. The tag is installed in either case.
  - After install: demand -> HDR; prefetch -> IDLE.
- Requests arriving while busy wait, non-preemptive. A demand request pending at the end of a prefetch is accepted in the first IDLE cycle.
- flush:
  - In IDLE, all valid bits clear at the next edge.
  - When busy, flush is latched and applied on the transition into IDLE. It applies after any tag install in the same transaction.
  - Requests are not accepted on the cycle the pending flush is applied.
- A refill to an occupied set overwrites it (direct-mapped).
- err clears only on reset.

Decomposition:
- Shared package items: the fetch_state_e enum; MORPH_S; the HDR_BANK=4 constant; the set/tag slice functions, parameterised on BLK_SHIFT/NUM_SETS.
- One natural sub-module: i_tag_array (valid+tag storage, 1-cycle registered compare, install and flush-all ports).
- Arbiter and FSM remain in i_fetch_ctrl.

Test Plan:
- Cold demand miss at addr 0x0000_1200:
  - l2_req until l2_gnt, then 40 beats with refill_bank sequencing 0..4 and chunk 0..7 each.
  - Then HDR, 8 ROWS cycles, fetch_done.
  - A re-fetch of the same address gives fetch_done exactly 11 cycles after fetch_ack.
- fetch_req and pf_req asserted together in IDLE with morph_mode==MORPH_S: fetch_ack first, pf_ack in the first IDLE cycle after that fetch_done.
- pf_req with morph_mode!=MORPH_S: pf_ack never asserts.
- Prefetch miss installs the block with no hdr_valid/row_valid. A subsequent demand fetch to that address hits: no l2_req, fetch_done at ack+11.
- l2_rsp_last on beat 20: err=1 and stays high; the tag is installed and the FSM continues to HDR.
- flush during ROWS: delivery completes and fetch_done pulses; the next fetch to the same address misses (l2_req asserts).
- rst_n low during MISS_WAIT: all outputs 0 in the same cycle; after release, the same address misses.
